// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver (LSB first) with a byte FIFO drained over
// a valid/ready handshake. The rx pin is double-flopped before any use.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  S_IDLE  | line idle, waiting for a synchronised falling edge
//  S_START | half-bit wait, then re-check start bit (rejects short glitches)
//  S_DATA  | sample 8 data bits mid-bit, shifting right into r_shreg
//  S_STOP  | sample stop bit: high pushes the byte, low flags a frame error
//  S_BREAK | line held low after a framing error, wait for it to go high

module uart_rx_fifo #(
    parameter int FREQUENCY  = 25_000_000,
    parameter int BAUDRATE   = 115_200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          ser_rx,
    output logic [7:0]                    rdata_o,
    output logic                          rvalid_o,
    input  logic                          rready_i,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          frame_err_o,
    output logic                          overrun_o,
    input  logic                          clr_overrun_i
);

    localparam int CLKS_PER_BIT = FREQUENCY / BAUDRATE;
    localparam int TW           = $clog2(CLKS_PER_BIT);
    localparam int AW           = $clog2(FIFO_DEPTH);

    localparam logic [TW-1:0] FULL_BIT = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_BIT = TW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;
    logic w_rx_s;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= ser_rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    // ------------------------------------------------------------------
    // Receive FSM with bit timer
    // ------------------------------------------------------------------
    state_t          r_state;
    logic [TW-1:0]   r_timer;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shreg;
    logic            r_frame_err;
    logic            w_timer_zero;

    assign w_timer_zero = (r_timer == '0);

    // Frame decoder: the timer is reloaded on every state change so each
    // sample lands mid-bit relative to the synchronised start edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_bit_idx   <= '0;
            r_shreg     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= S_START;
                        r_timer <= HALF_BIT;
                    end
                end
                S_START: begin
                    if (w_timer_zero) begin
                        r_timer <= FULL_BIT;
                        if (!w_rx_s) begin
                            r_state   <= S_DATA;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_timer_zero) begin
                        r_shreg   <= {w_rx_s, r_shreg[7:1]};
                        r_timer   <= FULL_BIT;
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_timer_zero) begin
                        r_timer <= FULL_BIT;
                        if (w_rx_s) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_BREAK;
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_BREAK: begin
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                        r_timer <= FULL_BIT;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_timer <= FULL_BIT;
                end
            endcase
        end
    end

    // A good stop bit writes the byte on the same edge it is sampled.
    logic       w_push;
    logic [7:0] w_din;

    assign w_push = (r_state == S_STOP) && w_timer_zero && w_rx_s;
    assign w_din  = r_shreg;

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic [AW:0] r_count;
    logic [7:0]  r_rdata;
    logic        r_overrun;

    logic        w_full;
    logic        w_empty;
    logic        w_pop;
    logic        w_wr;
    logic [AW:0] w_wptr_nxt;
    logic [AW:0] w_rptr_nxt;

    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_empty = (r_wptr == r_rptr);
    assign w_pop   = !w_empty && rready_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_wr    = w_push && (!w_full || w_pop);

    assign w_wptr_nxt = w_wr  ? r_wptr + (AW+1)'(1) : r_wptr;
    assign w_rptr_nxt = w_pop ? r_rptr + (AW+1)'(1) : r_rptr;

    // Storage array; contents only matter once written, so no reset.
    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_mem[r_wptr[AW-1:0]] <= w_din;
        end
    end

    // Pointers, occupancy, registered head byte and sticky overrun.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_rdata   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_count <= w_wptr_nxt - w_rptr_nxt;
            // The head slot may be the one being written this very cycle;
            // when the FIFO goes empty the last head value is kept.
            if (w_wptr_nxt != w_rptr_nxt) begin
                r_rdata <= (w_rptr_nxt == r_wptr) ? w_din : r_mem[w_rptr_nxt[AW-1:0]];
            end
            if (w_push && w_full && !w_pop) begin
                r_overrun <= 1'b1;
            end else if (clr_overrun_i) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign rdata_o     = r_rdata;
    assign rvalid_o    = (r_count != '0);
    assign count_o     = r_count;
    assign frame_err_o = r_frame_err;
    assign overrun_o   = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 25 MHz / 115200 baud (217 clocks per bit).
`timescale 1ns/1ps

module tb_uart_rx_fifo;

    localparam int BCLK = 217;

    logic       clk = 1'b0;
    logic       rst;
    logic       ser_rx;
    logic [7:0] rdata;
    logic       rvalid;
    logic       rready;
    logic [3:0] count;
    logic       frame_err;
    logic       overrun;
    logic       clr_overrun;

    int n_cmp = 0;
    int n_err = 0;
    int fe_cnt = 0;

    uart_rx_fifo #(
        .FREQUENCY  (25_000_000),
        .BAUDRATE   (115_200),
        .FIFO_DEPTH (8)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .ser_rx        (ser_rx),
        .rdata_o       (rdata),
        .rvalid_o      (rvalid),
        .rready_i      (rready),
        .count_o       (count),
        .frame_err_o   (frame_err),
        .overrun_o     (overrun),
        .clr_overrun_i (clr_overrun)
    );

    always #20 clk = ~clk;

    // Count frame error pulses seen on the output.
    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
    end

    // Drive one 10-bit frame starting at the current negedge. When pop_at is
    // non-negative, rready is raised for exactly one cycle at that offset.
    task automatic send_byte(input logic [7:0] b, input int bclk,
                             input logic stop_val, input int pop_at);
        for (int c = 0; c < 10 * bclk; c++) begin
            int k;
            k = c / bclk;
            if (k == 0)      ser_rx = 1'b0;
            else if (k == 9) ser_rx = stop_val;
            else             ser_rx = b[k-1];
            if (pop_at >= 0) begin
                if (c == pop_at)          rready = 1'b1;
                else if (c == pop_at + 1) rready = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic pop_one();
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ser_rx = 1'b1; rready = 1'b0; clr_overrun = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
        n_cmp++; if (rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata: got %h want 00", rdata); end
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (overrun !== 1'b0 || frame_err !== 1'b0) begin n_err++; $display("FAIL reset_flags: got ovr=%b fe=%b want 0 0", overrun, frame_err); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++; if (count !== 4'd0 || rvalid !== 1'b0) begin n_err++; $display("FAIL post_reset: got count=%0d rvalid=%b want 0 0", count, rvalid); end
    endtask

    task automatic test_two_bytes();
        int fe0;
        fe0 = fe_cnt;
        send_byte(8'hA5, BCLK, 1'b1, -1);
        send_byte(8'h3C, BCLK, 1'b1, -1);
        repeat (10) @(negedge clk);
        n_cmp++; if (count !== 4'd2) begin n_err++; $display("FAIL t1_count: got %0d want 2", count); end
        n_cmp++; if (rvalid !== 1'b1) begin n_err++; $display("FAIL t1_rvalid: got %b want 1", rvalid); end
        n_cmp++; if (rdata !== 8'hA5) begin n_err++; $display("FAIL t1_head0: got %h want a5", rdata); end
        pop_one();
        n_cmp++; if (rdata !== 8'h3C) begin n_err++; $display("FAIL t1_head1: got %h want 3c", rdata); end
        n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL t1_count1: got %0d want 1", count); end
        pop_one();
        n_cmp++; if (rvalid !== 1'b0 || count !== 4'd0) begin n_err++; $display("FAIL t1_empty: got rvalid=%b count=%0d want 0 0", rvalid, count); end
        n_cmp++; if (rdata !== 8'h3C) begin n_err++; $display("FAIL t1_hold: got %h want 3c", rdata); end
        pop_one();
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL t1_pop_empty: got %0d want 0", count); end
        n_cmp++; if (fe_cnt - fe0 !== 0) begin n_err++; $display("FAIL t1_frame_err: got %0d pulses want 0", fe_cnt - fe0); end
    endtask

    task automatic test_glitch();
        int fe0;
        fe0 = fe_cnt;
        ser_rx = 1'b0;
        repeat (100) @(negedge clk);
        ser_rx = 1'b1;
        repeat (400) @(negedge clk);
        n_cmp++; if (count !== 4'd0 || rvalid !== 1'b0) begin n_err++; $display("FAIL t2_count: got count=%0d rvalid=%b want 0 0", count, rvalid); end
        n_cmp++; if (fe_cnt - fe0 !== 0) begin n_err++; $display("FAIL t2_frame_err: got %0d pulses want 0", fe_cnt - fe0); end
    endtask

    task automatic test_frame_error();
        int fe0;
        fe0 = fe_cnt;
        send_byte(8'h55, BCLK, 1'b0, -1);
        repeat (2 * BCLK) @(negedge clk);
        ser_rx = 1'b1;
        repeat (50) @(negedge clk);
        n_cmp++; if (fe_cnt - fe0 !== 1) begin n_err++; $display("FAIL t3_fe_pulses: got %0d want 1", fe_cnt - fe0); end
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL t3_count: got %0d want 0", count); end
        send_byte(8'h12, BCLK, 1'b1, -1);
        repeat (10) @(negedge clk);
        n_cmp++; if (count !== 4'd1 || rdata !== 8'h12) begin n_err++; $display("FAIL t3_next: got count=%0d data=%h want 1 12", count, rdata); end
        n_cmp++; if (fe_cnt - fe0 !== 1) begin n_err++; $display("FAIL t3_fe_total: got %0d want 1", fe_cnt - fe0); end
        pop_one();
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 9; i++) begin
            send_byte(8'(i), BCLK, 1'b1, -1);
        end
        repeat (10) @(negedge clk);
        n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL t4_count: got %0d want 8", count); end
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL t4_overrun: got %b want 1", overrun); end
        n_cmp++; if (rdata !== 8'h00) begin n_err++; $display("FAIL t4_head: got %h want 00", rdata); end
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        @(negedge clk);
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL t4_clr: got %b want 0", overrun); end
    endtask

    // Stop sample lands on the 2064th rising edge after the start negedge.
    task automatic test_full_push_pop();
        logic [7:0] exp [8];
        exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h09};
        send_byte(8'h09, BCLK, 1'b1, 2063);
        repeat (10) @(negedge clk);
        n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL t5_count: got %0d want 8", count); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL t5_overrun: got %b want 0", overrun); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (rdata !== exp[i]) begin n_err++; $display("FAIL t5_drain[%0d]: got %h want %h", i, rdata, exp[i]); end
            pop_one();
        end
        n_cmp++; if (count !== 4'd0 || rvalid !== 1'b0) begin n_err++; $display("FAIL t5_empty: got count=%0d rvalid=%b want 0 0", count, rvalid); end
    endtask

    task automatic test_reset_mid_frame();
        send_byte(8'h77, BCLK, 1'b1, -1);
        repeat (10) @(negedge clk);
        n_cmp++; if (count !== 4'd1 || rdata !== 8'h77) begin n_err++; $display("FAIL t6_pre: got count=%0d data=%h want 1 77", count, rdata); end
        // start bit plus four zero data bits of 0xF0
        ser_rx = 1'b0;
        repeat (5 * BCLK) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (rvalid !== 1'b0 || count !== 4'd0) begin n_err++; $display("FAIL t6_rst_fifo: got rvalid=%b count=%0d want 0 0", rvalid, count); end
        n_cmp++; if (rdata !== 8'h00 || overrun !== 1'b0 || frame_err !== 1'b0) begin n_err++; $display("FAIL t6_rst_out: got data=%h ovr=%b fe=%b want 00 0 0", rdata, overrun, frame_err); end
        ser_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        send_byte(8'h0F, BCLK, 1'b1, -1);
        repeat (10) @(negedge clk);
        n_cmp++; if (count !== 4'd1 || rdata !== 8'h0F) begin n_err++; $display("FAIL t6_after: got count=%0d data=%h want 1 0f", count, rdata); end
        pop_one();
    endtask

    task automatic test_back_to_back();
        int         fe0;
        logic [7:0] fast [3];
        logic [7:0] slow [3];
        fast = '{8'hC3, 8'h81, 8'h7E};
        slow = '{8'h5A, 8'hA5, 8'hFF};
        fe0 = fe_cnt;
        for (int i = 0; i < 3; i++) send_byte(slow[i], 224, 1'b1, -1);
        repeat (20) @(negedge clk);
        n_cmp++; if (count !== 4'd3) begin n_err++; $display("FAIL t7_slow_count: got %0d want 3", count); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (rdata !== slow[i]) begin n_err++; $display("FAIL t7_slow[%0d]: got %h want %h", i, rdata, slow[i]); end
            pop_one();
        end
        for (int i = 0; i < 3; i++) send_byte(fast[i], 210, 1'b1, -1);
        repeat (20) @(negedge clk);
        n_cmp++; if (count !== 4'd3) begin n_err++; $display("FAIL t7_fast_count: got %0d want 3", count); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (rdata !== fast[i]) begin n_err++; $display("FAIL t7_fast[%0d]: got %h want %h", i, rdata, fast[i]); end
            pop_one();
        end
        n_cmp++; if (fe_cnt - fe0 !== 0 || overrun !== 1'b0) begin n_err++; $display("FAIL t7_errors: got fe=%0d ovr=%b want 0 0", fe_cnt - fe0, overrun); end
    endtask

    initial begin
        rst = 1'b1; ser_rx = 1'b1; rready = 1'b0; clr_overrun = 1'b0;
        @(negedge clk);
        test_reset();
        test_two_bytes();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_full_push_pop();
        test_reset_mid_frame();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
